kamacore_pipeline_reg: RTL and testbench

KAMACORE_PIPELINE_REG -- requirements
Module: kamacore_pipeline_reg

---
 rtl/kamacore_pipeline_reg.sv | 105 ++++++++++
 tb/tb_kamacore_pipeline_reg.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kamacore_pipeline_reg.sv
// Valid/ready pipeline stage with optional skid slot, stall (hold) and kill (flush).
// Bubbles always present out_ctrl = 0 so downstream never sees a write strobe.
module kamacore_pipeline_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_WIDTH   = 5,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned SKID_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [1:0]            occupancy
);

  localparam int unsigned EW = DATA_WIDTH + RD_WIDTH + CTRL_WIDTH;

  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] skid_q, skid_d;
  logic [EW-1:0] in_entry;
  logic [1:0]    occ_q, occ_d;
  logic          ready_int;
  logic          accept;
  logic          dispatch;

  assign in_entry  = {in_data, in_rd, in_ctrl};
  assign out_valid = (occ_q != 2'd0) && !hold && !flush;
  assign {out_data, out_rd} = head_q[EW-1:CTRL_WIDTH];
  assign out_ctrl  = out_valid ? head_q[CTRL_WIDTH-1:0] : '0;
  assign occupancy = occ_q;

  assign accept   = in_valid && ready_int;
  assign dispatch = out_valid && out_ready;

  // Reset only gates the visible port so that the stage advertises ready
  // in the very first cycle after release.
  assign in_ready = ready_int && rst;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic ready_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (occ_d != 2'd2);
        end
      end

      assign ready_int = ready_q && !hold && !flush;
    end else begin : g_single
      assign ready_int = !hold && !flush && ((occ_q == 2'd0) || out_ready);
    end
  endgenerate

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = 2'd0;
    end else if (dispatch) begin
      if (occ_q == 2'd2) begin
        head_d = skid_q;
        occ_d  = 2'd1;
      end else if (accept) begin
        head_d = in_entry;
      end else begin
        occ_d = 2'd0;
      end
    end else if (accept) begin
      if (occ_q == 2'd0) begin
        head_d = in_entry;
        occ_d  = 2'd1;
      end else begin
        skid_d = in_entry;
        occ_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_kamacore_pipeline_reg.sv
// Directed bench: skid (SKID_EN=1) and single-entry (SKID_EN=0) instances,
// expected payloads queued at issue and checked by per-instance output monitors.
module tb_kamacore_pipeline_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid0 = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_ready0 = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic [7:0]  in_ctrl = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;

  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [4:0]  out_rd0;
  logic [7:0]  out_ctrl0;
  logic [1:0]  occupancy0;

  logic [44:0] sb_q[$];
  logic [44:0] q0[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kamacore_pipeline_reg #(.DATA_WIDTH(32), .RD_WIDTH(5), .CTRL_WIDTH(8), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  kamacore_pipeline_reg #(.DATA_WIDTH(32), .RD_WIDTH(5), .CTRL_WIDTH(8), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_rd(out_rd0), .out_ctrl(out_ctrl0),
    .occupancy(occupancy0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r, input logic [7:0] c);
    in_valid = v;
    in_data  = d;
    in_rd    = r;
    in_ctrl  = c;
  endtask

  // Monitors: a dispatch is out_valid && out_ready seen just before the edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL skid_unexpected actual=0x%0h required=none", {out_data, out_rd, out_ctrl});
      end else begin
        logic [44:0] e;
        e = sb_q.pop_front();
        chk("skid_payload", {19'd0, out_data, out_rd, out_ctrl}, {19'd0, e});
        $display("skid  out data=0x%08h rd=%0d ctrl=0x%02h", out_data, out_rd, out_ctrl);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL single_unexpected actual=0x%0h required=none", {out_data0, out_rd0, out_ctrl0});
      end else begin
        logic [44:0] e;
        e = q0.pop_front();
        chk("single_payload", {19'd0, out_data0, out_rd0, out_ctrl0}, {19'd0, e});
        $display("single out data=0x%08h rd=%0d ctrl=0x%02h", out_data0, out_rd0, out_ctrl0);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_in_ready0", in_ready0, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ctrl", out_ctrl, 8'd0);
    repeat (2) cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_occ", occupancy, 2'd0);

    // Single pass
    cyc();
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 5'd5, 8'h03);
    @(negedge clk);
    chk("single_in_ready", in_ready, 1'b1);
    sb_q.push_back({32'h1234_5678, 5'd5, 8'h03});
    cyc();
    drive(1'b0, 32'hDEAD_BEEF, 5'd31, 8'hFF);
    @(negedge clk);
    chk("single_occ1", occupancy, 2'd1);
    chk("single_out_valid", out_valid, 1'b1);
    cyc();
    @(negedge clk);
    chk("single_occ0", occupancy, 2'd0);
    chk("bubble_ctrl", out_ctrl, 8'd0);
    chk("bubble_data_held", out_data, 32'h1234_5678);

    // Backpressure: A, B fill both slots, C refused
    cyc();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 5'd1, 8'h11);
    @(negedge clk);
    chk("bp_a_ready", in_ready, 1'b1);
    sb_q.push_back({32'hAAAA_0001, 5'd1, 8'h11});
    cyc();
    drive(1'b1, 32'hBBBB_0002, 5'd2, 8'h22);
    @(negedge clk);
    chk("bp_b_ready", in_ready, 1'b1);
    chk("bp_occ1", occupancy, 2'd1);
    sb_q.push_back({32'hBBBB_0002, 5'd2, 8'h22});
    cyc();
    drive(1'b1, 32'hCCCC_0003, 5'd3, 8'h33);
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_head_ctrl", out_ctrl, 8'h11);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 8'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_occ2", occupancy, 2'd2);
    cyc();
    @(negedge clk);
    chk("bp_drain_occ1", occupancy, 2'd1);
    chk("bp_drain_valid", out_valid, 1'b1);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_drain_occ0", occupancy, 2'd0);

    // Hold for 3 cycles with an entry resident and a competing push
    cyc();
    drive(1'b1, 32'hDDDD_0003, 5'd3, 8'h44);
    @(negedge clk);
    sb_q.push_back({32'hDDDD_0003, 5'd3, 8'h44});
    cyc();
    hold = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'hEEEE_0004, 5'd4, 8'h55);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1'b0);
      chk("hold_out_ctrl", out_ctrl, 8'd0);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_occ", occupancy, 2'd1);
      if (i < 2) cyc();
    end
    cyc();
    hold = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 8'h0);
    @(negedge clk);
    chk("hold_release_valid", out_valid, 1'b1);
    chk("hold_release_data", out_data, 32'hDDDD_0003);
    chk("hold_release_ctrl", out_ctrl, 8'h44);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    cyc();
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_drain_occ", occupancy, 2'd0);

    // Flush at occupancy 2 with a concurrent push
    cyc();
    drive(1'b1, 32'hF1F1_0001, 5'd6, 8'h66);
    cyc();
    drive(1'b1, 32'hF2F2_0002, 5'd7, 8'h77);
    @(negedge clk);
    chk("flush_pre_occ", occupancy, 2'd1);
    cyc();
    flush = 1'b1;
    drive(1'b1, 32'h6666_0006, 5'd8, 8'h88);
    @(negedge clk);
    chk("flush_pre_occ2", occupancy, 2'd2);
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_ctrl", out_ctrl, 8'd0);
    cyc();
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 8'h0);
    @(negedge clk);
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_post_valid", out_valid, 1'b0);

    // Streaming on both variants; the single-entry one starts with X resident
    cyc();
    out_ready0 = 1'b0;
    in_valid0 = 1'b1;
    in_data = 32'h0000_00AA;
    in_rd = 5'd9;
    in_ctrl = 8'h5A;
    @(negedge clk);
    chk("s0_x_ready", in_ready0, 1'b1);
    q0.push_back({32'h0000_00AA, 5'd9, 8'h5A});
    cyc();
    @(negedge clk);
    chk("s0_full_ready", in_ready0, 1'b0);
    chk("s0_full_occ", occupancy0, 2'd1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      out_ready0 = 1'b1;
      in_valid0 = 1'b1;
      drive(1'b1, 32'(i), 5'(i), 8'(i + 1));
      @(negedge clk);
      chk("stream_ready", in_ready, 1'b1);
      chk("stream_ready0", in_ready0, 1'b1);
      chk("stream_occ0", occupancy0, 2'd1);
      if (i > 0) begin
        chk("stream_occ", occupancy, 2'd1);
        chk("stream_valid", out_valid, 1'b1);
      end
      sb_q.push_back({32'(i), 5'(i), 8'(i + 1)});
      q0.push_back({32'(i), 5'(i), 8'(i + 1)});
    end
    cyc();
    drive(1'b0, 32'h0, 5'd0, 8'h0);
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("stream_tail_occ", occupancy, 2'd1);
    cyc();
    @(negedge clk);
    chk("stream_end_occ", occupancy, 2'd0);
    chk("stream_end_occ0", occupancy0, 2'd0);

    // Asynchronous reset between edges at occupancy 2
    cyc();
    out_ready = 1'b0;
    out_ready0 = 1'b0;
    drive(1'b1, 32'h4848_0001, 5'd10, 8'h99);
    cyc();
    drive(1'b1, 32'h4848_0002, 5'd11, 8'h9A);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 8'h0);
    @(negedge clk);
    chk("arst_pre_occ", occupancy, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_occ", occupancy, 2'd0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_ctrl", out_ctrl, 8'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_rd", out_rd, 5'd0);
    chk("arst_in_ready", in_ready, 1'b0);
    cyc();
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", in_ready, 1'b1);
    chk("arst_release_valid", out_valid, 1'b0);

    repeat (3) cyc();
    chk("sb_empty", sb_q.size(), 0);
    chk("q0_empty", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
